// File: rtl/cluster_frame_builder.sv
// cluster_frame_builder
//   Captures the 8 sorted clusters of a bunch crossing on frame_strobe_in and
//   canonicalises the invalid ones. It counts the valid clusters and
//   serialises the frame as four 32-bit link words, two clusters per clock4x
//   cycle. It also keeps the orbit BX counter.
// Ports
//   clock4x          160 MHz clock
//   global_reset_n   async reset, active-low
//   frame_strobe_in  1-cycle pulse, clusters_in belong to the current BX
//   bc0_in           orbit marker, only looked at together with the strobe
//   clusters_in      8 x {cnt[2:0],adr[10:0]}, cluster k at [14k+13:14k]
//   frame_word       {slot[1:0], full, parity, cluster 2k, cluster 2k+1}
//   frame_valid      frame_word carries a slot
//   frame_start      high with slot 0
//   cluster_count    valid clusters of the frame on the link (0..8)
//   bx_count         BX number of the frame on the link
//   strobe_err_cnt   saturating count of strobes that cut a frame short

// Per-cluster lane: flags an out-of-range address and substitutes the
// canonical empty cluster for it.
module cluster_canon #(
  parameter int N_STRIPS = 1536
) (
  input  logic [13:0] raw,
  output logic [13:0] canon,
  output logic        valid
);
  localparam logic [11:0] ADR_LIMIT = 12'(N_STRIPS);

  assign valid = {1'b0, raw[10:0]} < ADR_LIMIT;
  assign canon = valid ? raw : 14'h07FF;
endmodule

module cluster_frame_builder #(
  parameter int N_STRIPS = 1536,
  parameter int BX_MAX   = 3563
) (
  input  logic         clock4x,
  input  logic         global_reset_n,
  input  logic         frame_strobe_in,
  input  logic         bc0_in,
  input  logic [111:0] clusters_in,
  output logic [31:0]  frame_word,
  output logic         frame_valid,
  output logic         frame_start,
  output logic [3:0]   cluster_count,
  output logic [11:0]  bx_count,
  output logic [7:0]   strobe_err_cnt
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 14;
  localparam logic [11:0] BX_LAST = 12'(BX_MAX);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  state_t state, state_nxt;
  logic   early;

  logic [NUM_LANES-1:0][VEC_W-1:0] canon;
  logic [NUM_LANES-1:0]            lane_ok;
  logic [3:0]                      cnt_nxt;
  logic [11:0]                     bx_nxt;

  logic [NUM_LANES-1:0][VEC_W-1:0] cap_clu;
  logic [3:0]                      cap_cnt;
  logic [11:0]                     bx_cnt;

  // Canonicalise lanes
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    cluster_canon #(.N_STRIPS(N_STRIPS)) u_canon (
      .raw   (clusters_in[VEC_W*k +: VEC_W]),
      .canon (canon[k]),
      .valid (lane_ok[k])
    );
  end

  always_comb begin
    cnt_nxt = 4'd0;
    for (int k = 0; k < NUM_LANES; k++)
      cnt_nxt = cnt_nxt + {3'b000, lane_ok[k]};
  end

  // BX counter follows the captures; bc0 forces the orbit start.
  always_comb begin
    if (bc0_in)                bx_nxt = 12'd0;
    else if (bx_cnt == BX_LAST) bx_nxt = 12'd0;
    else                       bx_nxt = bx_cnt + 12'd1;
  end

  // FSM
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) state <= IDLE;
    else                  state <= state_nxt;
  end

  // A strobe before S3 restarts the frame with the new data; only S3 and
  // IDLE may take a strobe without it counting as an error.
  always_comb begin
    state_nxt = state;
    early     = 1'b0;
    case (state)
      IDLE: if (frame_strobe_in) state_nxt = S0;
      S0: begin
        state_nxt = S1;
        if (frame_strobe_in) begin state_nxt = S0; early = 1'b1; end
      end
      S1: begin
        state_nxt = S2;
        if (frame_strobe_in) begin state_nxt = S0; early = 1'b1; end
      end
      S2: begin
        state_nxt = S3;
        if (frame_strobe_in) begin state_nxt = S0; early = 1'b1; end
      end
      S3:      state_nxt = frame_strobe_in ? S0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      cap_clu <= {NUM_LANES{14'h07FF}};
      cap_cnt <= 4'd0;
      bx_cnt  <= 12'd0;
    end else if (frame_strobe_in) begin
      cap_clu <= canon;
      cap_cnt <= cnt_nxt;
      bx_cnt  <= bx_nxt;
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n)                    strobe_err_cnt <= 8'd0;
    else if (early && strobe_err_cnt != 8'hFF) strobe_err_cnt <= strobe_err_cnt + 8'd1;
  end

  // Output word, one cycle behind the state so slot 0 follows the capture.
  logic [1:0]  slot;
  logic        active;
  logic [27:0] payload;
  logic [31:0] word_nxt;

  always_comb begin
    slot   = 2'd0;
    active = 1'b1;
    case (state)
      S0:      slot = 2'd0;
      S1:      slot = 2'd1;
      S2:      slot = 2'd2;
      S3:      slot = 2'd3;
      default: active = 1'b0;
    endcase
    payload  = {cap_clu[{slot, 1'b0}], cap_clu[{slot, 1'b1}]};
    word_nxt = active ? {slot, cap_cnt == 4'd8, ^payload, payload} : 32'd0;
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      frame_word    <= 32'd0;
      frame_valid   <= 1'b0;
      frame_start   <= 1'b0;
      cluster_count <= 4'd0;
      bx_count      <= 12'd0;
    end else begin
      frame_word  <= word_nxt;
      frame_valid <= active;
      frame_start <= (state == S0);
      if (state == S0) begin
        cluster_count <= cap_cnt;
        bx_count      <= bx_cnt;
      end
    end
  end
endmodule

// File: tb/tb_cluster_frame_builder.sv
module tb_cluster_frame_builder;
  logic         clock4x = 1'b0;
  logic         global_reset_n;
  logic         frame_strobe_in = 1'b0;
  logic         bc0_in = 1'b0;
  logic [111:0] clusters_in = '0;
  logic [31:0]  frame_word;
  logic         frame_valid;
  logic         frame_start;
  logic [3:0]   cluster_count;
  logic [11:0]  bx_count;
  logic [7:0]   strobe_err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  cluster_frame_builder dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .frame_strobe_in(frame_strobe_in),
    .bc0_in         (bc0_in),
    .clusters_in    (clusters_in),
    .frame_word     (frame_word),
    .frame_valid    (frame_valid),
    .frame_start    (frame_start),
    .cluster_count  (cluster_count),
    .bx_count       (bx_count),
    .strobe_err_cnt (strobe_err_cnt)
  );

  always #5 clock4x = ~clock4x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of pending link slots ----------------
  typedef struct {
    logic [31:0] word;
    logic        start;
    logic [3:0]  cc;
    logic [11:0] bx;
  } slot_t;

  slot_t       q[$];
  logic [31:0] exp_word  = 0;
  logic        exp_valid = 0;
  logic        exp_start = 0;
  logic [3:0]  exp_cc    = 0;
  logic [11:0] exp_bx    = 0;
  logic [7:0]  exp_err   = 0;
  int          m_bx      = 0;

  task automatic model_reset();
    q.delete();
    exp_word = 0; exp_valid = 0; exp_start = 0;
    exp_cc = 0; exp_bx = 0; exp_err = 0; m_bx = 0;
  endtask

  task automatic model_step();
    slot_t       e;
    logic [13:0] c [8];
    int          cnt;
    logic [27:0] pl;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_word = e.word; exp_valid = 1; exp_start = e.start;
      if (e.start) begin exp_cc = e.cc; exp_bx = e.bx; end
    end else begin
      exp_word = 0; exp_valid = 0; exp_start = 0;
    end
    if (frame_strobe_in) begin
      // slots still pending mean the previous frame is being cut short
      if (q.size() > 0 && exp_err != 8'd255) exp_err = exp_err + 8'd1;
      q.delete();
      m_bx = bc0_in ? 0 : (m_bx == 3563 ? 0 : m_bx + 1);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
        c[k] = clusters_in[14*k +: 14];
        if (int'(c[k][10:0]) >= 1536) c[k] = 14'h07FF;
        else cnt++;
      end
      for (int s = 0; s < 4; s++) begin
        pl = {c[2*s], c[2*s+1]};
        e.word  = {2'(s), cnt == 8, ^pl, pl};
        e.start = (s == 0);
        e.cc    = 4'(cnt);
        e.bx    = 12'(m_bx);
        q.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clock4x or negedge global_reset_n);
    if (!global_reset_n) model_reset();
    else                 model_step();
  end

  // compare every cycle, away from the edge
  initial forever begin
    @(posedge clock4x);
    #2;
    chk("frame_word",     frame_word,             exp_word);
    chk("frame_valid",    {31'd0, frame_valid},   {31'd0, exp_valid});
    chk("frame_start",    {31'd0, frame_start},   {31'd0, exp_start});
    chk("cluster_count",  {28'd0, cluster_count}, {28'd0, exp_cc});
    chk("bx_count",       {20'd0, bx_count},      {20'd0, exp_bx});
    chk("strobe_err_cnt", {24'd0, strobe_err_cnt}, {24'd0, exp_err});
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [111:0] c, input logic b);
    frame_strobe_in = 1'b1; bc0_in = b; clusters_in = c;
    @(negedge clock4x);
    frame_strobe_in = 1'b0; bc0_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock4x);
  endtask

  function automatic logic [111:0] pattern(input int i);
    logic [111:0] v;
    for (int k = 0; k < 8; k++) v[14*k +: 14] = 14'((i * 37 + k * 211) % 16384);
    return v;
  endfunction

  logic [111:0] v;

  initial begin
    global_reset_n = 1'b0;
    idle(3);
    chk("reset_word",  frame_word,             32'd0);
    chk("reset_valid", {31'd0, frame_valid},   32'd0);
    chk("reset_bx",    {20'd0, bx_count},      32'd0);
    chk("reset_err",   {24'd0, strobe_err_cnt}, 32'd0);
    global_reset_n = 1'b1;
    idle(2);

    // 1/5: full frame with bc0, then nothing
    for (int k = 0; k < 8; k++) v[14*k +: 14] = {3'(k), 11'(10 * (k + 1))};
    pulse(v, 1'b1);
    idle(1);
    chk("t1_slot0_word", frame_word, 32'h3002_8814);
    chk("t1_start",      {31'd0, frame_start},   32'd1);
    chk("t1_count",      {28'd0, cluster_count}, 32'd8);
    chk("t1_bx",         {20'd0, bx_count},      32'd0);
    idle(3);
    chk("t1_slot3_word", frame_word, 32'hEC11_B850);
    idle(1);
    chk("t5_idle_valid", {31'd0, frame_valid},   32'd0);
    chk("t5_idle_word",  frame_word,             32'd0);
    chk("t5_hold_count", {28'd0, cluster_count}, 32'd8);
    chk("t5_hold_bx",    {20'd0, bx_count},      32'd0);
    idle(3);

    // 2: three valid, one out of range (adr 1600), rest empty
    for (int k = 0; k < 3; k++) v[14*k +: 14] = {3'd1, 11'(100 * (k + 1))};
    v[14*3 +: 14] = {3'd5, 11'd1600};
    for (int k = 4; k < 8; k++) v[14*k +: 14] = {3'd0, 11'h7FF};
    pulse(v, 1'b0);
    idle(2);
    chk("t2_slot1_lo",  {18'd0, frame_word[13:0]}, 32'h07FF);
    chk("t2_full",      {31'd0, frame_word[29]},   32'd0);
    chk("t2_count",     {28'd0, cluster_count},    32'd3);
    chk("t2_bx",        {20'd0, bx_count},         32'd1);
    idle(6);

    // 3: back-to-back frames across the orbit wrap
    for (int i = 0; i < 3570; i++) begin
      pulse(pattern(i), i == 0);
      if (i == 3563 || i == 3564 || i == 3569) begin
        idle(1);
        chk("t3_bx", {20'd0, bx_count}, (i == 3563) ? 32'd3563 : (i == 3564) ? 32'd0 : 32'd5);
        chk("t3_valid", {31'd0, frame_valid}, 32'd1);
        idle(2);
      end else idle(3);
    end
    idle(1);
    chk("t3_err", {24'd0, strobe_err_cnt}, 32'd0);
    idle(4);

    // 4: early strobe, then saturation
    pulse(pattern(7), 1'b0);
    idle(1);
    pulse(pattern(8), 1'b0);
    idle(1);
    chk("t4_err_one", {24'd0, strobe_err_cnt}, 32'd1);
    idle(5);
    for (int i = 0; i < 300; i++) pulse(pattern(100 + i), 1'b0);
    idle(6);
    chk("t4_err_sat", {24'd0, strobe_err_cnt}, 32'd255);

    // 6: reset during slot 1
    pulse(pattern(55), 1'b0);
    idle(2);
    global_reset_n = 1'b0;
    #1;
    chk("t6_word",  frame_word,           32'd0);
    chk("t6_valid", {31'd0, frame_valid}, 32'd0);
    chk("t6_bx",    {20'd0, bx_count},    32'd0);
    idle(2);
    global_reset_n = 1'b1;
    idle(6);
    chk("t6_quiet", {31'd0, frame_valid}, 32'd0);
    pulse(pattern(56), 1'b0);
    idle(1);
    chk("t6_bx_restart", {20'd0, bx_count}, 32'd1);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
